// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// port index constants and the data pattern returned on a timed-out read.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam logic       PORT_IF          = 1'b0;
    localparam logic       PORT_LS          = 1'b1;
    localparam logic [7:0] MEM_ARB_ERR_DATA = 8'hFF;

endpackage : mem_arb_pkg

// File: rtl/mem_arb_timer.sv
// BUSY-phase watchdog for mem_arbiter. Counts cycles while i_run is high and
// flags expiry on the cycle whose count equals LIMIT-1. i_clear restarts the
// count (asserted on the grant edge, so counting begins with the first BUSY cycle).
module mem_arb_timer #(
    parameter logic [19:0] LIMIT = 20'd1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired
);

    logic [19:0] r_count;

    // Cycle counter: cleared on grant, advances on every BUSY cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 20'd0;
        end else if (i_clear) begin
            r_count <= 20'd0;
        end else if (i_run) begin
            r_count <= r_count + 20'd1;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_expired = i_run && (r_count == (LIMIT - 20'd1));

endmodule : mem_arb_timer

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single CPU-side port of memory_com between the
// instruction-fetch path (port 0, read-only) and the load/store path
// (port 1, read/write). Round-robin grant, fields captured at grant and held
// through BUSY, one-cycle RELEASE gap before the next grant.
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort a BUSY phase that
// lasts TIMEOUT_CYCLES cycles without mem_done (done+err pulse, rdata 8'hFF).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    // port 0: instruction fetch
    input  logic       if_req,
    input  logic [7:0] if_addr,
    input  logic [2:0] if_size,
    output logic       if_done,
    output logic [7:0] if_rdata,
    output logic       if_err,
    // port 1: load/store
    input  logic       ls_req,
    input  logic       ls_we,
    input  logic [7:0] ls_addr,
    input  logic [7:0] ls_wdata,
    input  logic [2:0] ls_size,
    input  logic [1:0] ls_memwrite,
    output logic       ls_done,
    output logic [7:0] ls_rdata,
    output logic       ls_err,
    // memory_com side
    output logic       write_enable,
    output logic       read_enable,
    input  logic       mem_done,
    output logic [7:0] writeData,
    output logic [7:0] address,
    input  logic [7:0] readData,
    output logic [2:0] SizeLoad,
    output logic [1:0] MemWrite
);

    arb_state_t r_state, w_state_nxt;

    logic       r_last_grant, w_last_grant_nxt;
    logic       r_grant,      w_grant_nxt;
    logic       r_write_enable, w_write_enable_nxt;
    logic       r_read_enable,  w_read_enable_nxt;
    logic [7:0] r_address,    w_address_nxt;
    logic [7:0] r_write_data, w_write_data_nxt;
    logic [2:0] r_size,       w_size_nxt;
    logic [1:0] r_memwrite,   w_memwrite_nxt;
    logic       r_if_done,    w_if_done_nxt;
    logic       r_ls_done,    w_ls_done_nxt;
    logic       r_if_err,     w_if_err_nxt;
    logic       r_ls_err,     w_ls_err_nxt;
    logic [7:0] r_if_rdata,   w_if_rdata_nxt;
    logic [7:0] r_ls_rdata,   w_ls_rdata_nxt;

    logic       w_winner;
    logic       w_timer_clear;
    logic       w_expired;

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_timer #(
        .LIMIT     (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_timer_clear),
        .i_run     (r_state == BUSY),
        .o_expired (w_expired)
    );
`else
    // Without the watchdog BUSY waits for mem_done forever; the parameter and
    // the clear strobe are kept so both builds share one interface.
    logic w_unused_timeout;
    assign w_unused_timeout = ^{TIMEOUT_CYCLES, w_timer_clear};
    assign w_expired        = 1'b0;
`endif

    // Round-robin pick: on a tie the port that did not win last time wins.
    always_comb begin
        w_winner = PORT_IF;
        if (if_req && ls_req) begin
            w_winner = ~r_last_grant;
        end else if (if_req) begin
            w_winner = PORT_IF;
        end else begin
            w_winner = PORT_LS;
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_state_nxt        = r_state;
        w_last_grant_nxt   = r_last_grant;
        w_grant_nxt        = r_grant;
        w_write_enable_nxt = r_write_enable;
        w_read_enable_nxt  = r_read_enable;
        w_address_nxt      = r_address;
        w_write_data_nxt   = r_write_data;
        w_size_nxt         = r_size;
        w_memwrite_nxt     = r_memwrite;
        w_if_done_nxt      = 1'b0;
        w_ls_done_nxt      = 1'b0;
        w_if_err_nxt       = 1'b0;
        w_ls_err_nxt       = 1'b0;
        w_if_rdata_nxt     = r_if_rdata;
        w_ls_rdata_nxt     = r_ls_rdata;
        w_timer_clear      = 1'b0;

        case (r_state)
            IDLE: begin
                if (if_req || ls_req) begin
                    w_state_nxt      = BUSY;
                    w_grant_nxt      = w_winner;
                    w_last_grant_nxt = w_winner;
                    w_timer_clear    = 1'b1;
                    if (w_winner == PORT_IF) begin
                        // fetch port is read-only: write fields forced to zero
                        w_address_nxt      = if_addr;
                        w_write_data_nxt   = 8'h00;
                        w_size_nxt         = if_size;
                        w_memwrite_nxt     = 2'b00;
                        w_read_enable_nxt  = 1'b1;
                        w_write_enable_nxt = 1'b0;
                    end else begin
                        w_address_nxt      = ls_addr;
                        w_write_data_nxt   = ls_wdata;
                        w_size_nxt         = ls_size;
                        w_memwrite_nxt     = ls_memwrite;
                        w_read_enable_nxt  = ~ls_we;
                        w_write_enable_nxt = ls_we;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end

            BUSY: begin
                if (mem_done) begin
                    // normal completion takes priority over a same-edge expiry
                    w_state_nxt        = RELEASE;
                    w_read_enable_nxt  = 1'b0;
                    w_write_enable_nxt = 1'b0;
                    if (r_grant == PORT_IF) begin
                        w_if_done_nxt  = 1'b1;
                        w_if_rdata_nxt = readData;
                    end else begin
                        w_ls_done_nxt = 1'b1;
                        if (!r_write_enable) begin
                            w_ls_rdata_nxt = readData;
                        end else begin
                            w_ls_rdata_nxt = r_ls_rdata;
                        end
                    end
                end else if (w_expired) begin
                    w_state_nxt        = RELEASE;
                    w_read_enable_nxt  = 1'b0;
                    w_write_enable_nxt = 1'b0;
                    if (r_grant == PORT_IF) begin
                        w_if_done_nxt  = 1'b1;
                        w_if_err_nxt   = 1'b1;
                        w_if_rdata_nxt = MEM_ARB_ERR_DATA;
                    end else begin
                        w_ls_done_nxt = 1'b1;
                        w_ls_err_nxt  = 1'b1;
                        if (!r_write_enable) begin
                            w_ls_rdata_nxt = MEM_ARB_ERR_DATA;
                        end else begin
                            w_ls_rdata_nxt = r_ls_rdata;
                        end
                    end
                end else begin
                    w_state_nxt = BUSY;
                end
            end

            RELEASE: begin
                w_state_nxt        = IDLE;
                w_read_enable_nxt  = 1'b0;
                w_write_enable_nxt = 1'b0;
            end

            default: begin
                w_state_nxt        = IDLE;
                w_read_enable_nxt  = 1'b0;
                w_write_enable_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_last_grant   <= PORT_LS;
            r_grant        <= PORT_IF;
            r_write_enable <= 1'b0;
            r_read_enable  <= 1'b0;
            r_address      <= 8'h00;
            r_write_data   <= 8'h00;
            r_size         <= 3'b000;
            r_memwrite     <= 2'b00;
            r_if_done      <= 1'b0;
            r_ls_done      <= 1'b0;
            r_if_err       <= 1'b0;
            r_ls_err       <= 1'b0;
            r_if_rdata     <= 8'h00;
            r_ls_rdata     <= 8'h00;
        end else begin
            r_state        <= w_state_nxt;
            r_last_grant   <= w_last_grant_nxt;
            r_grant        <= w_grant_nxt;
            r_write_enable <= w_write_enable_nxt;
            r_read_enable  <= w_read_enable_nxt;
            r_address      <= w_address_nxt;
            r_write_data   <= w_write_data_nxt;
            r_size         <= w_size_nxt;
            r_memwrite     <= w_memwrite_nxt;
            r_if_done      <= w_if_done_nxt;
            r_ls_done      <= w_ls_done_nxt;
            r_if_err       <= w_if_err_nxt;
            r_ls_err       <= w_ls_err_nxt;
            r_if_rdata     <= w_if_rdata_nxt;
            r_ls_rdata     <= w_ls_rdata_nxt;
        end
    end

    assign write_enable = r_write_enable;
    assign read_enable  = r_read_enable;
    assign address      = r_address;
    assign writeData    = r_write_data;
    assign SizeLoad     = r_size;
    assign MemWrite     = r_memwrite;
    assign if_done      = r_if_done;
    assign ls_done      = r_ls_done;
    assign if_err       = r_if_err;
    assign ls_err       = r_ls_err;
    assign if_rdata     = r_if_rdata;
    assign ls_rdata     = r_ls_rdata;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter. Inputs change 1 time unit
// after a rising edge and outputs are sampled at that same point, well away
// from the next active edge. memory_com is played by hand (mem_done/readData).
module tb_mem_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [19:0] TB_TIMEOUT = 20'd16;
`else
    localparam logic [19:0] TB_TIMEOUT = 20'd1_000_000;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       if_req;
    logic [7:0] if_addr;
    logic [2:0] if_size;
    logic       if_done;
    logic [7:0] if_rdata;
    logic       if_err;
    logic       ls_req;
    logic       ls_we;
    logic [7:0] ls_addr;
    logic [7:0] ls_wdata;
    logic [2:0] ls_size;
    logic [1:0] ls_memwrite;
    logic       ls_done;
    logic [7:0] ls_rdata;
    logic       ls_err;
    logic       write_enable;
    logic       read_enable;
    logic       mem_done;
    logic [7:0] writeData;
    logic [7:0] address;
    logic [7:0] readData;
    logic [2:0] SizeLoad;
    logic [1:0] MemWrite;

    int n_total = 0;
    int n_bad   = 0;

    mem_arbiter #(
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_size      (if_size),
        .if_done      (if_done),
        .if_rdata     (if_rdata),
        .if_err       (if_err),
        .ls_req       (ls_req),
        .ls_we        (ls_we),
        .ls_addr      (ls_addr),
        .ls_wdata     (ls_wdata),
        .ls_size      (ls_size),
        .ls_memwrite  (ls_memwrite),
        .ls_done      (ls_done),
        .ls_rdata     (ls_rdata),
        .ls_err       (ls_err),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .mem_done     (mem_done),
        .writeData    (writeData),
        .address      (address),
        .readData     (readData),
        .SizeLoad     (SizeLoad),
        .MemWrite     (MemWrite)
    );

    // 10-unit clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // all memory_com-facing and port outputs packed for one-shot checks
    function automatic logic [31:0] outs_vec();
        return {write_enable, read_enable, if_done, ls_done, if_err, ls_err,
                address, writeData, SizeLoad, MemWrite};
    endfunction

    initial begin
        reset = 1'b1; if_req = 1'b0; if_addr = 8'h00; if_size = 3'b000;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = 8'h00; ls_wdata = 8'h00;
        ls_size = 3'b000; ls_memwrite = 2'b00; mem_done = 1'b0; readData = 8'h00;
        tick(); tick();
        check("reset_outs", outs_vec(), 32'd0);
        check("reset_rdata", {16'd0, if_rdata, ls_rdata}, 32'd0);
        reset = 1'b0;
        tick();

        // ---- port 1 write ----
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 8'h03; ls_wdata = 8'h01;
        ls_size = 3'b100; ls_memwrite = 2'b10;
        tick();
        check("wr_we", {31'd0, write_enable}, 32'd1);
        check("wr_re", {31'd0, read_enable}, 32'd0);
        check("wr_fields", {16'd0, address, writeData}, {16'd0, 8'h03, 8'h01});
        check("wr_size_mw", {27'd0, SizeLoad, MemWrite}, {27'd0, 3'b100, 2'b10});
        ls_addr = 8'h55;
        tick(); tick();
        check("wr_addr_held", {24'd0, address}, 32'h03);
        check("wr_we_held", {30'd0, write_enable, read_enable}, 32'b10);
        mem_done = 1'b1;
        tick();
        check("wr_done", {28'd0, write_enable, read_enable, ls_done, ls_err}, 32'b0010);
        check("wr_rdata_keep", {24'd0, ls_rdata}, 32'h00);
        mem_done = 1'b0; ls_req = 1'b0;
        tick();
        check("wr_done_low", {29'd0, write_enable, read_enable, ls_done}, 32'd0);
        tick();

        // ---- port 0 read ----
        if_req = 1'b1; if_addr = 8'h10; if_size = 3'b010;
        tick();
        check("rd_re", {30'd0, write_enable, read_enable}, 32'b01);
        check("rd_fields", {19'd0, address, SizeLoad, MemWrite}, {19'd0, 8'h10, 3'b010, 2'b00});
        check("rd_wdata0", {24'd0, writeData}, 32'h00);
        tick();
        check("rd_re_held", {31'd0, read_enable}, 32'd1);
        readData = 8'hAA; mem_done = 1'b1;
        tick();
        check("rd_done", {29'd0, read_enable, if_done, ls_done}, 32'b010);
        check("rd_data", {24'd0, if_rdata}, 32'hAA);
        mem_done = 1'b0; if_req = 1'b0; readData = 8'h00;
        tick();
        check("rd_done_low", {31'd0, if_done}, 32'd0);
        check("rd_data_held", {24'd0, if_rdata}, 32'hAA);
        tick();

        // ---- round robin from reset, both requesting ----
        reset = 1'b1; tick(); reset = 1'b0;
        if_req = 1'b1; if_addr = 8'h30; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h20;
        tick();
        check("rr_first_if", {23'd0, read_enable, address}, {23'd0, 1'b1, 8'h30});
        mem_done = 1'b1; readData = 8'h11;
        tick();
        check("rr_if_done", {30'd0, if_done, read_enable}, 32'b10);
        mem_done = 1'b0;
        tick();
        check("rr_gap2", {31'd0, read_enable}, 32'd0);
        tick();
        check("rr_second_ls", {23'd0, read_enable, address}, {23'd0, 1'b1, 8'h20});
        mem_done = 1'b1; readData = 8'h22;
        tick();
        check("rr_ls_done", {23'd0, ls_done, ls_rdata}, {23'd0, 1'b1, 8'h22});
        mem_done = 1'b0;
        tick(); tick();
        check("rr_third_if", {23'd0, read_enable, address}, {23'd0, 1'b1, 8'h30});
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0; if_req = 1'b0; ls_req = 1'b0;
        tick(); tick();

        // ---- reset mid-BUSY ----
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 8'h44; ls_wdata = 8'h99;
        ls_size = 3'b001; ls_memwrite = 2'b01;
        tick(); tick();
        check("mid_busy_we", {31'd0, write_enable}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_outs", outs_vec(), 32'd0);
        check("mid_rst_rdata", {16'd0, if_rdata, ls_rdata}, 32'd0);
        tick();
        reset = 1'b0; ls_req = 1'b0; mem_done = 1'b1;
        tick();
        check("post_rst_memdone", outs_vec(), 32'd0);
        mem_done = 1'b0;
        if_req = 1'b1; if_addr = 8'h66; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h77;
        tick();
        check("post_rst_tie_if", {23'd0, read_enable, address}, {23'd0, 1'b1, 8'h66});
        if_req = 1'b0; ls_req = 1'b0;
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        tick(); tick();

        // ---- stuck memory: timeout or indefinite wait ----
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h08;
        tick();
        ls_req = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        for (int i = 0; i < 15; i++) tick();
        check("to_pre_busy", {30'd0, read_enable, ls_done}, 32'b10);
        tick();
        check("to_fire", {29'd0, read_enable, ls_done, ls_err}, 32'b011);
        check("to_rdata", {24'd0, ls_rdata}, 32'hFF);
        tick();
        check("to_pulse_end", {30'd0, ls_done, ls_err}, 32'd0);
`else
        for (int i = 0; i < 1000; i++) tick();
        check("no_to_busy", {29'd0, read_enable, ls_done, ls_err}, 32'b100);
        readData = 8'h5A; mem_done = 1'b1;
        tick();
        check("no_to_done", {23'd0, ls_done, ls_rdata}, {23'd0, 1'b1, 8'h5A});
        mem_done = 1'b0;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_mem_arbiter
